// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Instruction-memory read bus between the fetch sequencer and its memory.
//   mem_addr  : instruction address (driven by the sequencer, equals pc)
//   mem_rd    : instruction read request (driven by the sequencer)
//   mem_rdata : instruction read data (driven by the memory side)
// Modports:
//   master : sequencer side (drives addr/rd, samples rdata)
//   slave  : memory side (samples addr/rd, drives rdata)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Follows the 8-bit count of the CPU state-machine counter. Every +1 step of
// count (while enabled) advances the instruction cycle one phase:
// FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. Owns pc and ir, issues
// one-cycle phase strobes, halts on HALT_OPCODE and flags any non-+1 count
// jump as a sticky sequencing error.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset (highest priority)
//   enable     : same enable that drives the counter; gates phase advance
//   count      : state-machine count value
//   mem        : instruction memory bus (fetch_sequencer_if.master)
//   ir         : instruction register
//   phase      : 0 FETCH, 1 DECODE, 2 EXECUTE (also while halted), 3 WRITEBACK
//   decode_stb : one-cycle pulse on entering DECODE
//   exec_stb   : one-cycle pulse on entering EXECUTE
//   wb_stb     : one-cycle pulse on entering WRITEBACK
//   halted     : sticky, set once a halt opcode executes
//   seq_err    : sticky, set when count jumps by anything other than +1
//   retired    : (only with FETCH_SEQ_RETIRE_CNT_EN) count of WRITEBACK->FETCH
//                transitions, wraps at 16'hFFFF
//
// Optional feature macro: FETCH_SEQ_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 8,
    parameter logic [3:0]      HALT_OPCODE = 4'hF,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          count,
    fetch_sequencer_if.master   mem,
    output logic [DATA_W-1:0]   ir,
    output logic [1:0]          phase,
    output logic                decode_stb,
    output logic                exec_stb,
    output logic                wb_stb,
    output logic                halted,
    output logic                seq_err
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]         retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [7:0]          count_q;
    logic                seq_err_q, seq_err_d;
    logic                decode_stb_q, decode_stb_d;
    logic                exec_stb_q, exec_stb_d;
    logic                wb_stb_q, wb_stb_d;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    logic [15:0]         retired_q, retired_d;
`endif

    logic changed;
    logic is_inc;
    logic err_cond;
    logic step;
    logic halted_w;

    // count_q shadows count every cycle regardless of enable, so changes made
    // while disabled are silently absorbed instead of looking like a jump later.
    assign changed  = (count != count_q);
    assign is_inc   = (count == 8'(count_q + 8'd1));   // FF->00 wraps legally
    assign err_cond = enable & changed & ~is_inc;
    assign halted_w = (state_q == S_HALT);
    assign step     = enable & changed & is_inc & ~halted_w & ~seq_err_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        seq_err_d    = seq_err_q | err_cond;
        decode_stb_d = 1'b0;
        exec_stb_d   = 1'b0;
        wb_stb_d     = 1'b0;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
        retired_d    = retired_q;
`endif
        if (step) begin
            case (state_q)
                S_FETCH: begin
                    ir_d         = mem.mem_rdata;
                    state_d      = S_DECODE;
                    decode_stb_d = 1'b1;
                end
                S_DECODE: begin
                    state_d    = S_EXEC;
                    exec_stb_d = 1'b1;
                end
                S_EXEC: begin
                    if (ir_q[DATA_W-1 -: 4] == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end else begin
                        state_d  = S_WB;
                        wb_stb_d = 1'b1;
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + 1'b1;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
                    retired_d = retired_q + 16'd1;
`endif
                end
                default: begin
                    // S_HALT: only reset leaves this state
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            count_q      <= count;
            seq_err_q    <= 1'b0;
            decode_stb_q <= 1'b0;
            exec_stb_q   <= 1'b0;
            wb_stb_q     <= 1'b0;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
            retired_q    <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            count_q      <= count;
            seq_err_q    <= seq_err_d;
            decode_stb_q <= decode_stb_d;
            exec_stb_q   <= exec_stb_d;
            wb_stb_q     <= wb_stb_d;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
            retired_q    <= retired_d;
`endif
        end
    end

    // The halt state reports phase 2: the machine stopped inside EXECUTE.
    always_comb begin
        phase = 2'd0;
        case (state_q)
            S_FETCH:  phase = 2'd0;
            S_DECODE: phase = 2'd1;
            S_EXEC:   phase = 2'd2;
            S_WB:     phase = 2'd3;
            S_HALT:   phase = 2'd2;
            default:  phase = 2'd0;
        endcase
    end

    assign mem.mem_addr = pc_q;
    assign mem.mem_rd   = (state_q == S_FETCH);
    assign ir           = ir_q;
    assign decode_stb   = decode_stb_q;
    assign exec_stb     = exec_stb_q;
    assign wb_stb       = wb_stb_q;
    assign halted       = halted_w;
    assign seq_err      = seq_err_q;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    assign retired      = retired_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed, table-driven bench for fetch_sequencer. Each vector applies one
// cycle of inputs on the falling edge and compares every output 1 time unit
// after the following rising edge. Hand-written sequences cover halt, reset
// mid-instruction and pc wrap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  count;
    logic [15:0] ir;
    logic [1:0]  phase;
    logic        decode_stb, exec_stb, wb_stb, halted, seq_err;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer_if #(.DATA_W(16), .ADDR_W(8)) mem_bus ();

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .count      (count),
        .mem        (mem_bus),
        .ir         (ir),
        .phase      (phase),
        .decode_stb (decode_stb),
        .exec_stb   (exec_stb),
        .wb_stb     (wb_stb),
        .halted     (halted),
        .seq_err    (seq_err)
`ifdef FETCH_SEQ_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  cnt;
        logic [15:0] rdata;
        logic [1:0]  e_phase;
        logic        e_dec;
        logic        e_exe;
        logic        e_wb;
        logic        e_rd;
        logic        e_halt;
        logic        e_err;
        logic [7:0]  e_pc;
        logic [15:0] e_ir;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic apply(input logic rst, input logic en, input logic [7:0] cnt,
                         input logic [15:0] rdata);
        @(negedge clk);
        reset             = rst;
        enable            = en;
        count             = cnt;
        mem_bus.mem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string nm, input logic [1:0] e_phase,
                              input logic e_dec, input logic e_exe, input logic e_wb,
                              input logic e_rd, input logic e_halt, input logic e_err,
                              input logic [7:0] e_pc, input logic [15:0] e_ir);
        logic [33:0] got, exp;
        got = {phase, decode_stb, exec_stb, wb_stb, mem_bus.mem_rd, halted, seq_err,
               mem_bus.mem_addr, ir};
        exp = {e_phase, e_dec, e_exe, e_wb, e_rd, e_halt, e_err, e_pc, e_ir};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got ph=%0d dec=%b exe=%b wb=%b rd=%b halt=%b err=%b pc=%h ir=%h | required ph=%0d dec=%b exe=%b wb=%b rd=%b halt=%b err=%b pc=%h ir=%h",
                     nm, phase, decode_stb, exec_stb, wb_stb, mem_bus.mem_rd, halted,
                     seq_err, mem_bus.mem_addr, ir, e_phase, e_dec, e_exe, e_wb,
                     e_rd, e_halt, e_err, e_pc, e_ir);
        end else begin
            $display("ok   %s ph=%0d dec=%b exe=%b wb=%b rd=%b halt=%b err=%b pc=%h ir=%h",
                     nm, phase, decode_stb, exec_stb, wb_stb, mem_bus.mem_rd, halted,
                     seq_err, mem_bus.mem_addr, ir);
        end
    endtask

`ifdef FETCH_SEQ_RETIRE_CNT_EN
    task automatic check_retired(input string nm, input logic [15:0] e_ret);
        checks++;
        if (retired !== e_ret) begin
            errors++;
            $display("FAIL %s retired got %h required %h", nm, retired, e_ret);
        end else begin
            $display("ok   %s retired=%h", nm, retired);
        end
    endtask
`endif

    initial begin
        //            rst   en    cnt    rdata     ph    dec   exe   wb    rd    halt  err   pc     ir
        // First step after reset loads ir and pulses decode
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 8'h06, 16'h1234, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1234};
        vecs[2]  = '{1'b0, 1'b1, 8'h06, 16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1234};
        // Full instruction from 8'h10
        vecs[3]  = '{1'b1, 1'b0, 8'h10, 16'h2001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 16'h2001, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h2001};
        vecs[5]  = '{1'b0, 1'b1, 8'h12, 16'h2001, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h2001};
        vecs[6]  = '{1'b0, 1'b1, 8'h13, 16'h2001, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h2001};
        vecs[7]  = '{1'b0, 1'b1, 8'h14, 16'h2001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h2001};
        vecs[8]  = '{1'b0, 1'b1, 8'h14, 16'h3333, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h2001};
        // Count wrap FE -> FF -> 00 is legal
        vecs[9]  = '{1'b1, 1'b0, 8'hFE, 16'h0ABC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 16'h0ABC, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0ABC};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 16'h0ABC, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0ABC};
        // Jump 20 -> 23 sets the sticky error and freezes the phase
        vecs[12] = '{1'b1, 1'b0, 8'h20, 16'h4444, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, 8'h23, 16'h4444, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000};
        vecs[14] = '{1'b0, 1'b1, 8'h24, 16'h4444, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000};
        vecs[15] = '{1'b0, 1'b1, 8'h25, 16'h4444, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0000};
        // Changes while disabled are absorbed
        vecs[16] = '{1'b1, 1'b0, 8'h40, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[17] = '{1'b0, 1'b0, 8'h47, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[18] = '{1'b0, 1'b1, 8'h48, 16'h5555, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h5555};
        vecs[19] = '{1'b0, 1'b1, 8'h49, 16'h5555, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h5555};

        reset = 1'b1;
        enable = 1'b0;
        count = 8'h00;
        mem_bus.mem_rdata = 16'h0000;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].rdata);
            check_outs($sformatf("vec%0d", i), vecs[i].e_phase, vecs[i].e_dec,
                       vecs[i].e_exe, vecs[i].e_wb, vecs[i].e_rd, vecs[i].e_halt,
                       vecs[i].e_err, vecs[i].e_pc, vecs[i].e_ir);
        end

        // Halt: F000 reaches EXECUTE, next step halts with no wb_stb
        apply(1'b1, 1'b0, 8'h30, 16'hF000);
        check_outs("halt_rst", 2'd0, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000);
        apply(1'b0, 1'b1, 8'h31, 16'hF000);
        check_outs("halt_dec", 2'd1, 1, 0, 0, 0, 0, 0, 8'h00, 16'hF000);
        apply(1'b0, 1'b1, 8'h32, 16'h0000);
        check_outs("halt_exe", 2'd2, 0, 1, 0, 0, 0, 0, 8'h00, 16'hF000);
        apply(1'b0, 1'b1, 8'h33, 16'h0000);
        check_outs("halt_set", 2'd2, 0, 0, 0, 0, 1, 0, 8'h00, 16'hF000);
        apply(1'b0, 1'b1, 8'h34, 16'h0000);
        check_outs("halt_ign1", 2'd2, 0, 0, 0, 0, 1, 0, 8'h00, 16'hF000);
        apply(1'b0, 1'b1, 8'h35, 16'h0000);
        check_outs("halt_ign2", 2'd2, 0, 0, 0, 0, 1, 0, 8'h00, 16'hF000);
`ifdef FETCH_SEQ_RETIRE_CNT_EN
        check_retired("halt_noretire", 16'd0);
`endif
        apply(1'b1, 1'b0, 8'h35, 16'h0000);
        check_outs("halt_clear", 2'd0, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000);

        // Reset mid-instruction wins over a concurrent legal step
        apply(1'b1, 1'b0, 8'h50, 16'h1111);
        apply(1'b0, 1'b1, 8'h51, 16'h1111);
        check_outs("mid_dec", 2'd1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h1111);
        apply(1'b1, 1'b1, 8'h52, 16'h1111);
        check_outs("mid_rst", 2'd0, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000);

        // 256 back-to-back instructions: pc wraps FF -> 00
        begin
            logic [7:0] c;
            logic [7:0] e_pc;
            c = 8'h00;
            apply(1'b1, 1'b0, c, 16'h0007);
            for (int n = 0; n < 256; n++) begin
                for (int k = 0; k < 4; k++) begin
                    c = c + 8'd1;
                    apply(1'b0, 1'b1, c, 16'h0007);
                end
                e_pc = 8'(n + 1);
                if (n == 0 || n == 254 || n == 255)
                    check_outs($sformatf("pc_wrap%0d", n), 2'd0, 0, 0, 0, 1, 0, 0,
                               e_pc, 16'h0007);
            end
`ifdef FETCH_SEQ_RETIRE_CNT_EN
            check_retired("retire_256", 16'd256);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Downstream consumer of the 8-bit `count` output of the CPU state-machine counter.
- Each single-step increment of `count` advances the instruction cycle one phase: FETCH → DECODE → EXECUTE → WRITEBACK.
- Owns the program counter and the instruction register, and issues one-cycle phase strobes to the datapath.
- Detects halt opcodes, and detects illegal count jumps as a sticky sequencing error.

Parameters:
- DATA_W, 16, instruction word / memory read data width
- ADDR_W, 8, program counter and memory address width
- HALT_OPCODE, 4'hF, value of ir[15:12] that halts the sequencer
- RESET_PC, 0, program counter value after reset

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  same enable that drives the state-machine counter; gates phase advance
- count  input  8  state-machine count value
- mem_rdata  input  DATA_W  instruction memory read data, valid while mem_rd is high
- mem_addr  output  ADDR_W  instruction address; equals pc
- mem_rd  output  1  instruction read request
- ir  output  DATA_W  instruction register
- phase  output  2  current phase: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK
- decode_stb  output  1  one-cycle pulse on entering DECODE
- exec_stb  output  1  one-cycle pulse on entering EXECUTE
- wb_stb  output  1  one-cycle pulse on entering WRITEBACK
- halted  output  1  sticky; high once a halt opcode executes
- seq_err  output  1  sticky; count jumped by an amount other than +1

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous and active-high, and has priority over every other input.
- Reset values:
  - pc = mem_addr = RESET_PC
  - ir = 0, phase = FETCH (0), mem_rd = 1
  - all strobes = 0, halted = 0, seq_err = 0
  - count_q <= count, so no step is seen on the first post-reset cycle
- count_q register:
  - Loads count every cycle, independent of enable.
  - Defines changed = (count != count_q), combinational.
- step = enable & changed & (count == count_q + 1, mod 256) & ~halted & ~seq_err.
  - Wrap 8'hFF → 8'h00 is a legal step.
- Sequencing error:
  - Condition: enable & changed & count != count_q + 1.
  - Effect: seq_err <= 1 at the next edge and the phase is frozen.
  - Cleared only by reset. No strobes while seq_err = 1.
- Changes to count while enable = 0 are absorbed into count_q. They are neither steps nor errors.
- State machine (phase register plus a HALT state). Every transition happens at the rising edge following a cycle with step = 1:
  - FETCH: mem_rd = 1, mem_addr = pc. On step: ir <= mem_rdata; phase <= DECODE; decode_stb = 1 for the following cycle only.
  - DECODE: on step → EXECUTE; exec_stb pulse.
  - EXECUTE: on step:
    - If ir[15:12] == HALT_OPCODE → HALT: halted <= 1; no wb_stb; phase holds 2.
    - Otherwise → WRITEBACK; wb_stb pulse.
  - WRITEBACK: on step → FETCH; pc <= pc + 1, wrapping 2^ADDR_W−1 → 0.
  - HALT: mem_rd = 0; no strobes; pc and ir hold. Exit by reset only.
- Latency: strobes and the new phase appear exactly one clock after the cycle in which count first differs from count_q by +1.
- Strobes are never high for more than one cycle, and at most one strobe is high at a time.
- ir changes only on the FETCH → DECODE edge. mem_rd is 0 in every phase except FETCH.
- Reset mid-instruction discards ir and returns to FETCH at RESET_PC on the next edge.

Optional Feature:
- Macro: FETCH_SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output `retired [15:0]`.
  - Reset value 0.
  - Increments on each WRITEBACK → FETCH transition and wraps at 16'hFFFF.
  - A halted instruction does not count.
- When undefined: the port and its counter are absent, and all other behaviour is identical.

Test Plan:
- Reset with count = 8'h05 held, then count → 8'h06 with enable = 1 → one cycle later: decode_stb = 1 for 1 cycle, phase = 1, ir = mem_rdata (e.g. 16'h1234).
- Four consecutive +1 steps from count = 8'h10, mem_rdata = 16'h2001 → strobe sequence decode, exec, wb, each one cycle; phase returns to 0; pc = RESET_PC + 1.
- Count steps 8'hFE → 8'hFF → 8'h00 → legal; seq_err stays 0; phase advances on both steps.
- Count jumps 8'h20 → 8'h23 with enable = 1 → seq_err = 1 next cycle; phase frozen; further +1 steps produce no strobes until reset.
- ir = 16'hF000 reaches EXECUTE and steps → halted = 1, no wb_stb, mem_rd = 0; subsequent steps are ignored. Reset → halted = 0, phase = 0, pc = RESET_PC.
- enable = 0 while count changes 8'h40 → 8'h47 → no strobes and no seq_err. enable = 1 then count → 8'h48 → normal single advance.
